// File: rtl/interrupt_dispatch.sv
// -----------------------------------------------------------------------------
// interrupt_dispatch
// Sits between the IF/IE registers and the CPU core. It holds the master
// enable (IME), applies the one-instruction EI delay and, at an instruction
// boundary, takes over the CPU for a fixed 5-cycle service sequence:
// WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP. The JUMP cycle drives the vector and
// a one-hot pulse naming the IF bit to clear.
// O_WAKE (HALT wake) ignores IME and is purely combinational.
//
// Optional feature macro: INT_CANCEL_EN
//   defined   - the source is re-selected at the PUSH_HI edge from the
//               current pending set. If nothing is pending there, JUMP
//               vectors to 16'h0000 and clears nothing.
//   undefined - the source chosen at the taking boundary is kept.
// -----------------------------------------------------------------------------
module interrupt_dispatch #(
  parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  I_IF,
  input  logic [4:0]  I_IE,
  input  logic        I_BOUNDARY,
  input  logic        I_EI,
  input  logic        I_DI,
  input  logic        I_RETI,
  output logic        O_IME,
  output logic        O_BUSY,
  output logic        O_PUSH_HI,
  output logic        O_PUSH_LO,
  output logic        O_LOAD_PC,
  output logic [15:0] O_VECTOR,
  output logic [4:0]  O_IF_CLEAR,
  output logic        O_WAKE
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT1   = 3'd1,
    ST_WAIT2   = 3'd2,
    ST_PUSH_HI = 3'd3,
    ST_PUSH_LO = 3'd4,
    ST_JUMP    = 3'd5
  } state_t;

  state_t      state_q;
  logic        ime_q;
  logic        ei_pending_q;
  logic [4:0]  sel_q;
  logic        busy_q;
  logic        push_hi_q;
  logic        push_lo_q;
  logic        load_pc_q;
  logic [15:0] vector_q;
  logic [4:0]  if_clear_q;

  logic [4:0]  pending_s;
  logic [4:0]  sel_d;
  logic        take_s;

  // Isolate the lowest set bit: bit 0 (VBLANK) has the highest priority.
  function automatic logic [4:0] lowest_bit(input logic [4:0] p);
    return p & (~p + 5'd1);
  endfunction

  // Vector for a one-hot selection; an empty selection yields 0 so a
  // cancelled dispatch jumps to 16'h0000.
  function automatic logic [15:0] vector_for(input logic [4:0] sel);
    logic [15:0] v;
    case (sel)
      5'b00001: v = VECTOR_BASE;
      5'b00010: v = VECTOR_BASE + 16'd8;
      5'b00100: v = VECTOR_BASE + 16'd16;
      5'b01000: v = VECTOR_BASE + 16'd24;
      5'b10000: v = VECTOR_BASE + 16'd32;
      default:  v = 16'h0000;
    endcase
    return v;
  endfunction

  // Pending sources, their priority winner and the dispatch decision. The
  // decision looks at the IME value held before this boundary's update, so
  // the boundary that makes a delayed EI take effect cannot dispatch.
  always_comb begin
    pending_s = I_IF & I_IE;
    sel_d     = lowest_bit(pending_s);
    take_s    = I_BOUNDARY & ime_q & (|pending_s);
  end

  // Service sequencer with IME/EI bookkeeping. The outputs are registered
  // and take the value that belongs to the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ime_q        <= 1'b0;
      ei_pending_q <= 1'b0;
      sel_q        <= 5'd0;
      busy_q       <= 1'b0;
      push_hi_q    <= 1'b0;
      push_lo_q    <= 1'b0;
      load_pc_q    <= 1'b0;
      vector_q     <= 16'h0000;
      if_clear_q   <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_s) begin
            // The taking boundary ignores EI/DI/RETI.
            state_q      <= ST_WAIT1;
            sel_q        <= sel_d;
            ime_q        <= 1'b0;
            ei_pending_q <= 1'b0;
            busy_q       <= 1'b1;
          end else if (I_BOUNDARY) begin
            if (I_DI) begin
              // DI wins over a simultaneous EI and cancels a delayed EI.
              ime_q        <= 1'b0;
              ei_pending_q <= 1'b0;
            end else begin
              if (I_RETI || ei_pending_q) begin
                ime_q <= 1'b1;
              end else begin
                ime_q <= ime_q;
              end
              // A delayed EI is consumed here; a new EI arms the next one.
              ei_pending_q <= I_EI;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT1: begin
          state_q <= ST_WAIT2;
        end
        ST_WAIT2: begin
          state_q   <= ST_PUSH_HI;
          push_hi_q <= 1'b1;
`ifdef INT_CANCEL_EN
          // Late re-evaluation: IF/IE may have changed since the boundary.
          sel_q     <= sel_d;
`else
          sel_q     <= sel_q;
`endif
        end
        ST_PUSH_HI: begin
          state_q   <= ST_PUSH_LO;
          push_hi_q <= 1'b0;
          push_lo_q <= 1'b1;
        end
        ST_PUSH_LO: begin
          state_q    <= ST_JUMP;
          push_lo_q  <= 1'b0;
          load_pc_q  <= 1'b1;
          vector_q   <= vector_for(sel_q);
          if_clear_q <= sel_q;
        end
        ST_JUMP: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          load_pc_q  <= 1'b0;
          vector_q   <= 16'h0000;
          if_clear_q <= 5'd0;
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          push_hi_q  <= 1'b0;
          push_lo_q  <= 1'b0;
          load_pc_q  <= 1'b0;
          vector_q   <= 16'h0000;
          if_clear_q <= 5'd0;
        end
      endcase
    end
  end

  assign O_IME      = ime_q;
  assign O_BUSY     = busy_q;
  assign O_PUSH_HI  = push_hi_q;
  assign O_PUSH_LO  = push_lo_q;
  assign O_LOAD_PC  = load_pc_q;
  assign O_VECTOR   = vector_q;
  assign O_IF_CLEAR = if_clear_q;
  assign O_WAKE     = |pending_s;

endmodule

// File: tb/tb_interrupt_dispatch.sv
// -----------------------------------------------------------------------------
// tb_interrupt_dispatch
// Directed vector table (expected outputs after each clock edge) followed by
// randomized stimulus checked against a cycle-count reference model.
// -----------------------------------------------------------------------------
module tb_interrupt_dispatch;

  logic        clock;
  logic        reset;
  logic [4:0]  I_IF;
  logic [4:0]  I_IE;
  logic        I_BOUNDARY;
  logic        I_EI;
  logic        I_DI;
  logic        I_RETI;
  logic        O_IME;
  logic        O_BUSY;
  logic        O_PUSH_HI;
  logic        O_PUSH_LO;
  logic        O_LOAD_PC;
  logic [15:0] O_VECTOR;
  logic [4:0]  O_IF_CLEAR;
  logic        O_WAKE;

  interrupt_dispatch #(.VECTOR_BASE(16'h0040)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_IF       (I_IF),
    .I_IE       (I_IE),
    .I_BOUNDARY (I_BOUNDARY),
    .I_EI       (I_EI),
    .I_DI       (I_DI),
    .I_RETI     (I_RETI),
    .O_IME      (O_IME),
    .O_BUSY     (O_BUSY),
    .O_PUSH_HI  (O_PUSH_HI),
    .O_PUSH_LO  (O_PUSH_LO),
    .O_LOAD_PC  (O_LOAD_PC),
    .O_VECTOR   (O_VECTOR),
    .O_IF_CLEAR (O_IF_CLEAR),
    .O_WAKE     (O_WAKE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst, bnd, ei, di, reti;
    logic [4:0]  if_v, ie_v;
    logic        ime, busy, hi, lo, ld;
    logic [15:0] vec;
    logic [4:0]  clr;
  } vec_t;

`ifdef INT_CANCEL_EN
  localparam logic [15:0] CANCEL_VEC = 16'h0000;
  localparam logic [4:0]  CANCEL_CLR = 5'h00;
`else
  localparam logic [15:0] CANCEL_VEC = 16'h0048;
  localparam logic [4:0]  CANCEL_CLR = 5'h02;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: phase counts cycles into a service (0 = not servicing).
  int m_phase = 0;
  int m_idx   = -1;
  bit m_ime   = 1'b0;
  bit m_eip   = 1'b0;

  function automatic int low_index(input logic [4:0] p);
    for (int i = 0; i < 5; i++) begin
      if (p[i]) return i;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic rst, bnd, ei, di, reti,
                              input logic [4:0] if_v, ie_v,
                              input logic ime, busy, hi, lo, ld,
                              input logic [15:0] vec, input logic [4:0] clr);
    vec_t v;
    v.rst = rst; v.bnd = bnd; v.ei = ei; v.di = di; v.reti = reti;
    v.if_v = if_v; v.ie_v = ie_v;
    v.ime = ime; v.busy = busy; v.hi = hi; v.lo = lo; v.ld = ld;
    v.vec = vec; v.clr = clr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input vec_t v);
    logic [4:0] p;
    p = v.if_v & v.ie_v;
    if (v.rst) begin
      m_phase = 0; m_idx = -1; m_ime = 1'b0; m_eip = 1'b0;
    end else if (m_phase != 0) begin
      m_phase = (m_phase == 5) ? 0 : m_phase + 1;
`ifdef INT_CANCEL_EN
      if (m_phase == 3) m_idx = low_index(p);
`endif
    end else if (v.bnd) begin
      if (m_ime && p != 5'd0) begin
        m_phase = 1; m_idx = low_index(p); m_ime = 1'b0; m_eip = 1'b0;
      end else if (v.di) begin
        m_ime = 1'b0; m_eip = 1'b0;
      end else begin
        if (v.reti || m_eip) m_ime = 1'b1;
        m_eip = v.ei;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model across the edge and compare.
  task automatic apply(input vec_t v, input bit use_table);
    logic [15:0] evec;
    logic [4:0]  eclr;
    reset = v.rst; I_BOUNDARY = v.bnd; I_EI = v.ei; I_DI = v.di; I_RETI = v.reti;
    I_IF = v.if_v; I_IE = v.ie_v;
    #1;
    chk("wake", {15'd0, O_WAKE}, {15'd0, |(v.if_v & v.ie_v)});
    @(posedge clock);
    model_edge(v);
    @(negedge clock);
    cyc++;
    evec = (m_phase == 5 && m_idx >= 0) ? 16'h0040 + 16'(8 * m_idx) : 16'h0000;
    eclr = (m_phase == 5 && m_idx >= 0) ? 5'(1 << m_idx) : 5'd0;
    chk("model_ime",  {15'd0, O_IME},     {15'd0, m_ime});
    chk("model_busy", {15'd0, O_BUSY},    {15'd0, m_phase != 0});
    chk("model_hi",   {15'd0, O_PUSH_HI}, {15'd0, m_phase == 3});
    chk("model_lo",   {15'd0, O_PUSH_LO}, {15'd0, m_phase == 4});
    chk("model_ld",   {15'd0, O_LOAD_PC}, {15'd0, m_phase == 5});
    chk("model_vec",  O_VECTOR,           evec);
    chk("model_clr",  {11'd0, O_IF_CLEAR}, {11'd0, eclr});
    if (use_table) begin
      chk("tbl_ime",  {15'd0, O_IME},     {15'd0, v.ime});
      chk("tbl_busy", {15'd0, O_BUSY},    {15'd0, v.busy});
      chk("tbl_hi",   {15'd0, O_PUSH_HI}, {15'd0, v.hi});
      chk("tbl_lo",   {15'd0, O_PUSH_LO}, {15'd0, v.lo});
      chk("tbl_ld",   {15'd0, O_LOAD_PC}, {15'd0, v.ld});
      chk("tbl_vec",  O_VECTOR,           v.vec);
      chk("tbl_clr",  {11'd0, O_IF_CLEAR}, {11'd0, v.clr});
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t r;
    reset = 1'b1; I_IF = 5'd0; I_IE = 5'd0;
    I_BOUNDARY = 1'b0; I_EI = 1'b0; I_DI = 1'b0; I_RETI = 1'b0;

    //                rst  bnd  ei   di   reti IF     IE     ime  busy hi   lo   ld   vector    clr
    // Reset, then a boundary with IME 0: no dispatch, wake still high.
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,5'h00,5'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h01,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    // RETI enables at once; next boundary takes timer (IF 14 -> bit 2).
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b1,5'h00,5'h1F,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h14,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h14,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h14,5'h1F,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h14,5'h1F,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h14,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b1,16'h0050,5'h04));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h14,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    // EI delay: B0 arms, B1 enables without dispatch, B2 dispatches VBLANK.
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,5'h01,5'h01,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h01,5'h01,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h01,5'h01,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h01,5'h01,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h01,5'h01,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h01,5'h01,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h01,5'h01,1'b0,1'b1,1'b0,1'b0,1'b1,16'h0040,5'h01));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h01,5'h01,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    // EI and DI together: DI wins, pending IF never serviced.
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b0,5'h01,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h01,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h01,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    // Joypad dispatch, reset asserted while in PUSH_LO: no IF clear pulse.
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b1,5'h00,5'h1F,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h10,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h10,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h10,5'h1F,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h10,5'h1F,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,5'h10,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h10,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    // Serial taken, IF dropped before PUSH_HI: cancel behaviour differs.
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b1,5'h00,5'h1F,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h02,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h00,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h00,5'h1F,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h00,5'h1F,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h00,5'h1F,1'b0,1'b1,1'b0,1'b0,1'b1,CANCEL_VEC,CANCEL_CLR));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h00,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    // Plain DI after RETI: IME drops, pending source ignored.
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b1,5'h00,5'h1F,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b0,5'h00,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,5'h01,5'h1F,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00));

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1);

    // Randomized run checked only against the reference model.
    apply(mk(1'b1,1'b0,1'b0,1'b0,1'b0,5'h00,5'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00), 1'b0);
    for (int i = 0; i < 4000; i++) begin
      r = mk(1'b0,1'b0,1'b0,1'b0,1'b0,5'h00,5'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,5'h00);
      r.rst  = ($urandom_range(0, 149) == 0);
      r.bnd  = ($urandom_range(0, 2) != 0);
      r.ei   = ($urandom_range(0, 4) == 0);
      r.di   = ($urandom_range(0, 7) == 0);
      r.reti = ($urandom_range(0, 5) == 0);
      r.if_v = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
      r.ie_v = 5'($urandom_range(0, 31));
      apply(r, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_dispatch.md
# interrupt_dispatch

Interrupt dispatch sequencer between the interrupt flag/enable registers and the CPU core. It holds the master enable (IME) and applies the one-instruction EI delay. At an instruction boundary it picks the highest-priority pending, enabled source, takes over the CPU for a fixed 5-cycle service sequence (two waits, PC high push, PC low push, jump), and returns the one-hot IF bit to clear. It also raises a HALT wake request whenever any enabled source is pending, independent of IME.

## Interface
Parameters:
- VECTOR_BASE, 16'h0040, vector of source 0 (VBLANK); source n vectors to VECTOR_BASE + 8*n.

Ports:
- clock  in  1  system clock; one clock = one CPU M-cycle step
- reset  in  1  synchronous, active-high
- I_IF  in  5  current IF register {joypad, serial, timer, lcdstat, vblank}
- I_IE  in  5  current IE register, same bit order
- I_BOUNDARY  in  1  CPU is at an instruction boundary (next cycle is opcode fetch)
- I_EI  in  1  EI executed; valid with I_BOUNDARY
- I_DI  in  1  DI executed; valid with I_BOUNDARY
- I_RETI  in  1  RETI executed; valid with I_BOUNDARY
- O_IME  out  1  master enable
- O_BUSY  out  1  service sequence in progress; CPU stalls fetch
- O_PUSH_HI  out  1  CPU writes PC[15:8] to --SP this cycle
- O_PUSH_LO  out  1  CPU writes PC[7:0] to --SP this cycle
- O_LOAD_PC  out  1  CPU loads O_VECTOR into PC this cycle
- O_VECTOR  out  16  service vector; valid only while O_LOAD_PC is high
- O_IF_CLEAR  out  5  one-hot IF bit to clear; one-cycle pulse
- O_WAKE  out  1  combinational: |(I_IF & I_IE)

## Operation
- pending = I_IF & I_IE. Priority is bit0 highest, bit4 lowest; the selection is a one-hot lowest set bit.
- State machine: IDLE -> WAIT1 -> WAIT2 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE.
- IDLE -> WAIT1 when I_BOUNDARY & O_IME & |pending.
  - On that edge, IME clears and ei_pending clears.
  - The selection is latched into sel.
  - I_EI, I_DI and I_RETI are ignored on the taking boundary.
- O_BUSY = state != IDLE.
- O_PUSH_HI is high in PUSH_HI only. O_PUSH_LO is high in PUSH_LO only.
- In JUMP:
  - O_LOAD_PC = 1.
  - O_VECTOR = VECTOR_BASE + 8*index(sel).
  - O_IF_CLEAR = sel.
- EI: I_BOUNDARY & I_EI sets ei_pending. IME becomes 1 at the next I_BOUNDARY edge. A dispatch is not taken at that boundary; the IME check uses the pre-update value.
- DI: I_BOUNDARY & I_DI clears IME and ei_pending on that edge. If EI and DI are asserted together, DI wins.
- RETI: I_BOUNDARY & I_RETI sets IME on that edge (no delay).
- I_BOUNDARY is ignored while O_BUSY.
- Reset in any state: state = IDLE, IME = 0, ei_pending = 0, sel = 0. The sequence is abandoned with no IF clear.

## Timing
- Reset values: O_IME 0, O_BUSY 0, O_PUSH_HI 0, O_PUSH_LO 0, O_LOAD_PC 0, O_VECTOR 16'h0000, O_IF_CLEAR 0. O_WAKE follows its inputs.
- From a taking boundary edge T:
  - WAIT1 at T+1, WAIT2 at T+2.
  - PUSH_HI at T+3, PUSH_LO at T+4.
  - JUMP at T+5 (O_LOAD_PC, O_IF_CLEAR).
  - IDLE at T+6.
- Back-to-back: the earliest next dispatch needs a boundary with IME = 1, so an ISR with no EI/RETI never nests.
- IF changing during service does not alter sel unless INT_CANCEL_EN is defined.
- O_VECTOR is 0 outside JUMP.

## Configuration
- INT_CANCEL_EN: models late re-evaluation.
  - Defined: at the PUSH_HI edge, sel is re-selected from the current pending.
    - If pending is 0 there, JUMP drives O_VECTOR = 16'h0000 and O_IF_CLEAR = 0.
    - Otherwise the new highest-priority bit is used.
  - Undefined: sel is fixed at the taking boundary.

## Test plan
- Reset, IE = 5'h1F, IF = 5'h01, IME 0, boundary: no dispatch, O_WAKE = 1, O_BUSY stays 0.
- RETI at boundary, then boundary with IF = 5'h14, IE = 5'h1F -> PUSH_HI at T+3, PUSH_LO at T+4, JUMP at T+5 with O_VECTOR = 16'h0050 and O_IF_CLEAR = 5'h04; O_IME = 0 from T+1.
- EI at boundary B0 with IF = IE = 5'h01 -> no dispatch at B1 (IME goes 1 there), dispatch at B2 with vector 16'h0040.
- EI and DI at the same boundary -> O_IME stays 0, ei_pending 0; pending IF is never serviced.
- Dispatch of IF = 5'h10 (joypad, vector 16'h0060) with reset asserted in PUSH_LO -> next cycle all outputs at reset values, no O_IF_CLEAR pulse.
- INT_CANCEL_EN, IF = 5'h02 taken, IF dropped to 0 before PUSH_HI -> JUMP O_VECTOR = 16'h0000, O_IF_CLEAR = 0. Without the macro -> 16'h0048, O_IF_CLEAR = 5'h02.
